// File: rtl/mem_wait_gen_pkg.sv
// Types and helpers for mem_wait_gen; codes come from the shared mem_wait_defs.v.
// Latency: n/a (package).
// Backpressure: n/a.
`include "mem_wait_defs.v"

package mem_wait_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `MWG_ST_IDLE,
    ST_WAIT = `MWG_ST_WAIT,
    ST_HOLD = `MWG_ST_HOLD,
    ST_ERR  = `MWG_ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM = `MWG_RG_RAM,
    RG_ROM = `MWG_RG_ROM,
    RG_IO  = `MWG_RG_IO,
    RG_UNM = `MWG_RG_UNM
  } region_t;

  // Wait-cycle count for a decoded region.
  function automatic int ws_sel(region_t r, int ram, int rom, int io, int unm);
    case (r)
      RG_RAM:  return ram;
      RG_ROM:  return rom;
      RG_IO:   return io;
      default: return unm;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_gen_if.sv
// Processor-side bus strobes and wait/status lines of the wait-state generator.
// Latency: n/a (wiring only).
// Backpressure: nws low stalls the processor; nws_ext lets slow slaves add stalls.
interface mem_wait_gen_if;
  logic       nmem;
  logic       nio;
  logic       nr;
  logic       nw;
  logic [1:0] ab_hi;
  logic       nws_ext;
  logic       nws;
  logic       busy;
  logic [1:0] region;
  logic       nberr;

  modport master (
    output nmem, nio, nr, nw, ab_hi, nws_ext,
    input  nws, busy, region, nberr
  );

  modport slave (
    input  nmem, nio, nr, nw, ab_hi, nws_ext,
    output nws, busy, region, nberr
  );
endinterface

// File: rtl/mem_wait_defs.v
// Shared state and region codes for the wait-state generator and the bus monitor.
// Latency: n/a (text macros only).
// Backpressure: n/a.
`ifndef MEM_WAIT_DEFS_V
`define MEM_WAIT_DEFS_V

`define MWG_ST_IDLE 2'd0
`define MWG_ST_WAIT 2'd1
`define MWG_ST_HOLD 2'd2
`define MWG_ST_ERR  2'd3

`define MWG_RG_RAM  2'b00
`define MWG_RG_ROM  2'b01
`define MWG_RG_IO   2'b10
`define MWG_RG_UNM  2'b11

`endif

// File: rtl/mem_wait_gen_ws_counter.sv
// Loadable down-counter that saturates at zero (never wraps).
// Latency: load/decrement visible one clk1 edge later.
// Backpressure: none; load has priority over decrement.
module ws_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk1,
  input  logic             nreset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins; decrement is gated at zero so the count cannot wrap.
  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_wait_gen.sv
// Bus-cycle wait-state generator: per-region wait cycles on nws, merged with slave waits.
// Latency: nws drops the edge after a request starts; nws_ext reaches nws combinationally.
// Backpressure: MEM_WAIT_GEN_WATCHDOG_EN adds an abort (nberr) after TIMEOUT ext-wait edges.
module mem_wait_gen
  import mem_wait_gen_pkg::*;
#(
  parameter int RAM_WS = 1,
  parameter int ROM_WS = 2,
  parameter int IO_WS  = 3,
  parameter int UNM_WS = 0,
  parameter int CNT_W  = 4
`ifdef MEM_WAIT_GEN_WATCHDOG_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic          clk1,
  input  logic          nreset,
  mem_wait_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  region_t          r_region, w_region_nxt, w_region_dec;
  logic             r_req_q;
  logic             r_nws_i, w_nws_nxt;
  logic             w_req, w_start;
  logic [CNT_W-1:0] w_ws;
  logic             w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_val, w_cnt;
  logic             w_nberr_nxt;
  logic             w_timeout;

  assign w_req   = (!bus.nmem || !bus.nio) && (!bus.nr || !bus.nw);
  assign w_start = w_req && !r_req_q;

  // Region decode: any I/O strobe wins over memory space and address.
  always_comb begin
    w_region_dec = RG_RAM;
    if (!bus.nio)           w_region_dec = RG_IO;
    else if (bus.ab_hi[0])  w_region_dec = RG_UNM;
    else if (bus.ab_hi[1])  w_region_dec = RG_ROM;
    else                    w_region_dec = RG_RAM;
  end

  assign w_ws = CNT_W'(ws_sel(w_region_dec, RAM_WS, ROM_WS, IO_WS, UNM_WS));

  ws_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk1       (clk1),
    .nreset     (nreset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

`ifdef MEM_WAIT_GEN_WATCHDOG_EN
  logic             w_tload, w_tdec, w_tzero;
  logic [CNT_W-1:0] w_tcnt;
  logic             r_nberr;

  // Watchdog counts down from TIMEOUT on every ext-wait edge of an active cycle.
  assign w_tload   = (r_state == ST_IDLE) || (r_state == ST_ERR) || bus.nws_ext;
  assign w_tdec    = ((r_state == ST_WAIT) || (r_state == ST_HOLD)) && !bus.nws_ext && !w_tzero;
  assign w_timeout = w_tdec && (w_tcnt == C_ONE);

  ws_counter #(.CNT_W(CNT_W)) u_tcnt (
    .clk1       (clk1),
    .nreset     (nreset),
    .i_load     (w_tload),
    .i_load_val (CNT_W'(TIMEOUT)),
    .i_dec      (w_tdec),
    .o_cnt      (w_tcnt),
    .o_zero     (w_tzero)
  );

  // One-cycle bus-error pulse on the edge the watchdog expires.
  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) r_nberr <= 1'b1;
    else         r_nberr <= w_nberr_nxt;
  end

  assign bus.nberr = r_nberr;
  assign bus.nws   = r_nws_i && (bus.nws_ext || (r_state == ST_ERR));
`else
  assign w_timeout = 1'b0;
  assign bus.nberr = 1'b1;
  assign bus.nws   = r_nws_i && bus.nws_ext;
`endif

  // Next-state logic: start classification, wait countdown, hold, abort.
  always_comb begin
    w_state_nxt  = r_state;
    w_region_nxt = r_region;
    w_nws_nxt    = r_nws_i;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;
    w_nberr_nxt  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_region_nxt = w_region_dec;
          if (w_ws != '0) begin
            w_cnt_load  = 1'b1;
            w_cnt_val   = w_ws;
            w_nws_nxt   = 1'b0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_nws_nxt   = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_nws_nxt   = 1'b1;
          w_cnt_load  = 1'b1;
          w_nberr_nxt = 1'b0;
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_dec = 1'b1;
          if ((w_cnt == C_ONE) || w_cnt_zero) begin
            w_nws_nxt   = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_nberr_nxt = 1'b0;
          w_state_nxt = ST_ERR;
        end
      end
`ifdef MEM_WAIT_GEN_WATCHDOG_EN
      ST_ERR: begin
        if (!w_req) w_state_nxt = ST_IDLE;
      end
`endif
      default: begin
        w_nws_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, region, internal wait and request-edge registers.
  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ST_IDLE;
      r_region <= RG_RAM;
      r_nws_i  <= 1'b1;
      r_req_q  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_region <= w_region_nxt;
      r_nws_i  <= w_nws_nxt;
      r_req_q  <= w_req;
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.region = r_region;

endmodule

// File: tb/tb_mem_wait_gen.sv
// Directed bench for mem_wait_gen with hand-computed expectations.
// Latency: checks sampled 2 time units after each rising clk1 edge.
// Backpressure: MEM_WAIT_GEN_WATCHDOG_EN selects the watchdog expectations.
module tb_mem_wait_gen;

  logic clk1   = 1'b0;
  logic nreset = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   lows;
  int   starts;
  int   nws_low_seen;
  logic prev_busy;
  int   pat6 [6] = '{1, 1, 0, 1, 0, 0};

  mem_wait_gen_if bus ();

  mem_wait_gen dut (
    .clk1   (clk1),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #2;
  endtask

  task automatic drive(input logic m, input logic io, input logic r, input logic w,
                       input logic [1:0] a);
    bus.nmem  = m;
    bus.nio   = io;
    bus.nr    = r;
    bus.nw    = w;
    bus.ab_hi = a;
  endtask

  task automatic idle_bus();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    idle_bus();
    bus.nws_ext = 1'b1;
    #12;
    chk("rst_nws", bus.nws, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_region", bus.region, 0);
    chk("rst_nberr", bus.nberr, 1);
    nreset = 1'b1;
    step();

    // 1: async reset in the middle of a ROM wait
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
    step();
    chk("t1_rom_nws0", bus.nws, 0);
    chk("t1_rom_region", bus.region, 1);
    step();
    chk("t1_rom_nws1", bus.nws, 0);
    chk("t1_rom_busy", bus.busy, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("t1_arst_nws", bus.nws, 1);
    chk("t1_arst_busy", bus.busy, 0);
    chk("t1_arst_region", bus.region, 0);
    idle_bus();
    #1;
    nreset = 1'b1;
    step();
    chk("t1_post_busy", bus.busy, 0);
    chk("t1_post_nws", bus.nws, 1);

    // 2: RAM read, one wait cycle, busy until strobe release
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    chk("t2_nws_e0", bus.nws, 0);
    chk("t2_region", bus.region, 0);
    chk("t2_busy_e0", bus.busy, 1);
    step();
    chk("t2_nws_e1", bus.nws, 1);
    chk("t2_busy_e1", bus.busy, 1);
    step();
    chk("t2_busy_hold", bus.busy, 1);
    idle_bus();
    step();
    chk("t2_busy_end", bus.busy, 0);

    // 3: IO write, three wait cycles; again with nmem also low
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
    step();
    chk("t3_region", bus.region, 2);
    chk("t3_nws_e0", bus.nws, 0);
    step();
    chk("t3_nws_e1", bus.nws, 0);
    step();
    chk("t3_nws_e2", bus.nws, 0);
    step();
    chk("t3_nws_e3", bus.nws, 1);
    idle_bus();
    step();
    chk("t3_idle", bus.busy, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.nws === 1'b0) lows++;
    end
    chk("t3_mem_io_low_cycles", lows, 3);
    chk("t3_mem_io_region", bus.region, 2);
    idle_bus();
    step();

    // 4: ROM read aborted after one wait cycle
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
    step();
    chk("t4_nws_e0", bus.nws, 0);
    idle_bus();
    step();
    chk("t4_abort_nws", bus.nws, 1);
    chk("t4_abort_busy", bus.busy, 0);
    chk("t4_abort_nberr", bus.nberr, 1);

    // 5: RAM with a slave holding nws_ext low for 20 cycles
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    chk("t5_nws_e0", bus.nws, 0);
    bus.nws_ext = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef MEM_WAIT_GEN_WATCHDOG_EN
      chk($sformatf("t5_nberr_%0d", i), bus.nberr, (i == 15) ? 1'b0 : 1'b1);
      chk($sformatf("t5_nws_%0d", i), bus.nws, (i >= 15) ? 1'b1 : 1'b0);
`else
      chk($sformatf("t5_nberr_%0d", i), bus.nberr, 1'b1);
      chk($sformatf("t5_nws_%0d", i), bus.nws, 1'b0);
`endif
      chk($sformatf("t5_busy_%0d", i), bus.busy, 1'b1);
    end
    bus.nws_ext = 1'b1;
    idle_bus();
    step();
    chk("t5_end_busy", bus.busy, 0);
    chk("t5_end_nws", bus.nws, 1);

    // 6: unmapped, back-to-back with a single idle edge between
    starts       = 0;
    nws_low_seen = 0;
    prev_busy    = bus.busy;
    for (int i = 0; i < 6; i++) begin
      if (pat6[i] != 0) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
      else              idle_bus();
      step();
      if (bus.busy && !prev_busy) starts++;
      if (bus.nws === 1'b0) nws_low_seen++;
      prev_busy = bus.busy;
      if (i == 0) chk("t6_region", bus.region, 3);
    end
    chk("t6_starts", starts, 2);
    chk("t6_nws_low", nws_low_seen, 0);
    chk("t6_end_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
